// File: rtl/unpack_sequencer.sv
// -----------------------------------------------------------------------------
// unpack_sequencer
//
// Operand-unpack sequencer for the FPU front end. A request carries an operand
// pair (or a single operand when unary=1). Both operands go through one shared
// significand-unpack datapath on successive cycles. Each operand's unpacked
// fields are registered and handed downstream with a valid/ready handshake.
//
// Unpack of an operand x:
//    db=1 : e = x[62:52], h = x[51:0]
//    db=0 : e = x[62:55], h = {x[54:32], 29'b0}   (single in the upper half)
//    f0   = {~(e==0), h}
//    lz   = leading zeros of f0 (53 when f0 is zero)
//    f    = normal ? f0 << lz : f0
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_valid   request valid
//    in_ready   request accepted when in_valid & in_ready (only in IDLE)
//    a, b       operands (b ignored for unary requests)
//    db         1 = double format, 0 = single format in x[63:32]
//    normal     1 = left-normalise the significand by its leading-zero count
//    unary      1 = single-operand request, B is skipped
//    out_valid  result valid
//    out_ready  consumer accepts when out_valid & out_ready
//    f_a, f_b   unpacked (optionally normalised) 53-bit significands
//    h_a, h_b   52-bit fraction fields
//    lz_a, lz_b leading-zero counts of {~e_z, h}
//    fz_a, fz_b fraction field is zero
//    ez_a, ez_b exponent field is zero
//    busy       sequencer is not idle
// -----------------------------------------------------------------------------
module unpack_sequencer #(
   parameter int N   = 64,
   parameter int LZW = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           db,
   input  logic           normal,
   input  logic           unary,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [52:0]    f_a,
   output logic [52:0]    f_b,
   output logic [51:0]    h_a,
   output logic [51:0]    h_b,
   output logic [LZW-1:0] lz_a,
   output logic [LZW-1:0] lz_b,
   output logic           fz_a,
   output logic           fz_b,
   output logic           ez_a,
   output logic           ez_b,
   output logic           busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S_A  = 2'd1,
      S_B  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic accept;

   // Latched copy of the request; the live inputs may change after acceptance.
   logic [N-1:0] a_q;
   logic [N-1:0] b_q;
   logic         db_q;
   logic         normal_q;
   logic         unary_q;

   // Shared unpack datapath signals.
   logic [N-1:0]   sel_op;
   logic [10:0]    exp_u;
   logic [51:0]    h_u;
   logic           ez_u;
   logic           fz_u;
   logic [52:0]    f0_u;
   logic [LZW-1:0] lz_u;
   logic           lz_found;
   logic [52:0]    f_u;

   // The sign bit plays no part in unpacking.
   logic unused_sign;

   assign accept = in_valid && in_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake outputs, all decoded from the state.
   // New requests are only taken in IDLE, so a result always leaves the block
   // before the next one starts.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_next = S_A;
            end
         end
         S_A: begin
            state_next = unary_q ? DONE : S_B;
         end
         S_B: begin
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request capture on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         db_q     <= 1'b0;
         normal_q <= 1'b0;
         unary_q  <= 1'b0;
      end else if (accept) begin
         a_q      <= a;
         b_q      <= b;
         db_q     <= db;
         normal_q <= normal;
         unary_q  <= unary;
      end
   end

   // Operand select for the shared datapath: B only while in S_B.
   assign sel_op      = (state == S_B) ? b_q : a_q;
   assign unused_sign = sel_op[N-1];

   // Field extraction. Single-format operands live in the upper half; their
   // 23-bit fraction is left-aligned into the 52-bit fraction field so both
   // formats share the same significand layout.
   always_comb begin
      exp_u = '0;
      h_u   = '0;
      if (db_q) begin
         exp_u = sel_op[62:52];
         h_u   = sel_op[51:0];
      end else begin
         exp_u = {3'b000, sel_op[62:55]};
         h_u   = {sel_op[54:32], 29'b0};
      end
   end

   assign ez_u = (exp_u == 11'd0);
   assign fz_u = (h_u == 52'd0);
   assign f0_u = {~ez_u, h_u};

   // Leading-zero count over the 53-bit significand, scanning from the MSB.
   // An all-zero significand yields 53.
   always_comb begin
      lz_u     = LZW'(53);
      lz_found = 1'b0;
      for (int i = 52; i >= 0; i--) begin
         if (!lz_found && f0_u[i]) begin
            lz_u     = LZW'(52 - i);
            lz_found = 1'b1;
         end
      end
   end

   // Optional normalisation; shifting by lz puts the leading one at bit 52.
   assign f_u = normal_q ? (f0_u << lz_u) : f0_u;

   // Result registers. A is captured in S_A and B in S_B. A unary request
   // clears the B side at A capture so stale B data never reaches the
   // consumer. Outside capture states the results simply hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_a  <= '0;
         h_a  <= '0;
         lz_a <= '0;
         fz_a <= 1'b0;
         ez_a <= 1'b0;
         f_b  <= '0;
         h_b  <= '0;
         lz_b <= '0;
         fz_b <= 1'b0;
         ez_b <= 1'b0;
      end else if (state == S_A) begin
         f_a  <= f_u;
         h_a  <= h_u;
         lz_a <= lz_u;
         fz_a <= fz_u;
         ez_a <= ez_u;
         if (unary_q) begin
            f_b  <= '0;
            h_b  <= '0;
            lz_b <= '0;
            fz_b <= 1'b0;
            ez_b <= 1'b0;
         end
      end else if (state == S_B) begin
         f_b  <= f_u;
         h_b  <= h_u;
         lz_b <= lz_u;
         fz_b <= fz_u;
         ez_b <= ez_u;
      end
   end

endmodule

// File: tb/tb_unpack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_unpack_sequencer
//
// Self-checking bench for unpack_sequencer. Expected results come from a
// behavioural model that computes the unpacked fields with plain arithmetic
// on the operand value. Directed cases cover the named corner values, reset
// (initial and mid-flight), backpressure and input hold; a randomized loop
// covers the rest.
// -----------------------------------------------------------------------------
module tb_unpack_sequencer;

   typedef struct packed {
      logic [52:0] f;
      logic [51:0] h;
      logic [5:0]  lz;
      logic        fz;
      logic        ez;
   } unp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        db;
   logic        normal;
   logic        unary;
   logic        out_valid;
   logic        out_ready;
   logic [52:0] f_a;
   logic [52:0] f_b;
   logic [51:0] h_a;
   logic [51:0] h_b;
   logic [5:0]  lz_a;
   logic [5:0]  lz_b;
   logic        fz_a;
   logic        fz_b;
   logic        ez_a;
   logic        ez_b;
   logic        busy;

   int compared;
   int mismatched;

   unpack_sequencer #(.N(64), .LZW(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .db        (db),
      .normal    (normal),
      .unary     (unary),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f_a       (f_a),
      .f_b       (f_b),
      .h_a       (h_a),
      .h_b       (h_b),
      .lz_a      (lz_a),
      .lz_b      (lz_b),
      .fz_a      (fz_a),
      .fz_b      (fz_b),
      .ez_a      (ez_a),
      .ez_b      (ez_b),
      .busy      (busy)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference unpack: exponent/fraction taken as numbers, leading zeros from
   // the position of the highest set bit of the 53-bit significand value.
   function automatic unp_t model(input logic [63:0] x, input logic fmt_db, input logic norm);
      unp_t            r;
      longint unsigned expo;
      longint unsigned frac;
      longint unsigned f0;
      longint unsigned ftmp;
      int              msb;
      if (fmt_db) begin
         expo = 64'(x[62:52]);
         frac = 64'(x[51:0]);
      end else begin
         expo = 64'(x[62:55]);
         frac = 64'(x[54:32]) * 64'd536870912;
      end
      f0  = ((expo != 0) ? (64'd1 << 52) : 64'd0) + frac;
      msb = -1;
      for (int i = 0; i < 53; i++) begin
         if ((f0 >> i) != 0) msb = i;
      end
      r.lz = 6'(52 - msb);
      ftmp = norm ? (f0 << (52 - msb)) : f0;
      r.f  = 53'(ftmp);
      r.h  = 52'(frac);
      r.fz = (frac == 0);
      r.ez = (expo == 0);
      return r;
   endfunction

   // Operand generator biased towards zero exponents, zero fractions and
   // small values so denormal and leading-zero paths get exercised.
   function automatic logic [63:0] randOperand();
      logic [63:0] x;
      x = {$urandom(), $urandom()};
      case ($urandom_range(0, 4))
         0: x = x;
         1: x[62:52] = '0;
         2: x[51:0] = '0;
         3: x[62:32] = '0;
         default: x = x >> $urandom_range(0, 63);
      endcase
      return x;
   endfunction

   task automatic compareAll(input string tag, input unp_t ea, input unp_t eb);
      checkOutput({tag, ":f_a"},  64'(f_a),  64'(ea.f));
      checkOutput({tag, ":h_a"},  64'(h_a),  64'(ea.h));
      checkOutput({tag, ":lz_a"}, 64'(lz_a), 64'(ea.lz));
      checkOutput({tag, ":fz_a"}, 64'(fz_a), 64'(ea.fz));
      checkOutput({tag, ":ez_a"}, 64'(ez_a), 64'(ea.ez));
      checkOutput({tag, ":f_b"},  64'(f_b),  64'(eb.f));
      checkOutput({tag, ":h_b"},  64'(h_b),  64'(eb.h));
      checkOutput({tag, ":lz_b"}, 64'(lz_b), 64'(eb.lz));
      checkOutput({tag, ":fz_b"}, 64'(fz_b), 64'(eb.fz));
      checkOutput({tag, ":ez_b"}, 64'(ez_b), 64'(eb.ez));
   endtask

   // One full transaction: accept, scramble the live inputs, wait for the
   // result with a bounded budget, check latency and data, hold off the
   // consumer for 'hold' cycles while poking a rival request, then release.
   task automatic applyStimulus(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                                input logic tdb, input logic tnorm, input logic tun,
                                input logic [63:0] post_a, input int hold);
      unp_t ea;
      unp_t eb;
      int   lat;
      ea = model(ta, tdb, tnorm);
      eb = tun ? '0 : model(tb, tdb, tnorm);
      checkOutput({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
      a        = ta;
      b        = tb;
      db       = tdb;
      normal   = tnorm;
      unary    = tun;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = post_a;
      b        = {$urandom(), $urandom()};
      db       = 1'($urandom_range(0, 1));
      normal   = 1'($urandom_range(0, 1));
      unary    = 1'($urandom_range(0, 1));
      checkOutput({tag, ":busy"}, 64'(busy), 64'd1);
      checkOutput({tag, ":in_ready_busy"}, 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({tag, ":latency"}, 64'(lat), tun ? 64'd1 : 64'd2);
      compareAll(tag, ea, eb);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a        = {$urandom(), $urandom()};
         @(posedge clk); #1;
         checkOutput({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
         checkOutput({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      if (hold > 0) compareAll({tag, ":held"}, ea, eb);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({tag, ":released_valid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, ":released_in_ready"}, 64'(in_ready), 64'd1);
      compareAll({tag, ":idle"}, ea, eb);
   endtask

   task automatic checkResetOutputs(input string tag);
      unp_t z;
      z = '0;
      checkOutput({tag, ":out_valid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, ":in_ready"}, 64'(in_ready), 64'd1);
      checkOutput({tag, ":busy"}, 64'(busy), 64'd0);
      compareAll(tag, z, z);
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      a          = '0;
      b          = '0;
      db         = 1'b0;
      normal     = 1'b0;
      unary      = 1'b0;
      #3;
      checkResetOutputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Double 1.0, unary, with the live operand overwritten after accept.
      applyStimulus("one", 64'h3FF0000000000000, 64'h0, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 0);
      checkOutput("one:f_a_const", 64'(f_a), 64'h10000000000000);
      checkOutput("one:lz_a_const", 64'(lz_a), 64'd0);
      checkOutput("one:fz_a_const", 64'(fz_a), 64'd1);
      checkOutput("one:ez_a_const", 64'(ez_a), 64'd0);

      // Double denormal against signed zero.
      applyStimulus("denorm", 64'h1, 64'h8000000000000000, 1'b1, 1'b1, 1'b0, 64'h0, 0);
      checkOutput("denorm:lz_a_const", 64'(lz_a), 64'd52);
      checkOutput("denorm:f_a_const", 64'(f_a), 64'h10000000000000);
      checkOutput("denorm:lz_b_const", 64'(lz_b), 64'd53);
      checkOutput("denorm:fz_b_const", 64'(fz_b), 64'd1);

      // Single denormal, unnormalised then normalised.
      applyStimulus("sgl_raw", 64'h0040000000000000, 64'h0, 1'b0, 1'b0, 1'b1, 64'h0, 0);
      checkOutput("sgl_raw:h_a_const", 64'(h_a), 64'h8000000000000);
      checkOutput("sgl_raw:lz_a_const", 64'(lz_a), 64'd1);
      checkOutput("sgl_raw:f_a_const", 64'(f_a), 64'h08000000000000);
      applyStimulus("sgl_norm", 64'h0040000000000000, 64'h0, 1'b0, 1'b1, 1'b1, 64'h0, 0);
      checkOutput("sgl_norm:f_a_const", 64'(f_a), 64'h10000000000000);

      // Backpressure on a binary request.
      applyStimulus("bp", 64'h4009_21FB_5444_2D18, 64'h0000_0000_0000_0F00, 1'b1, 1'b1, 1'b0, 64'h0, 5);

      // Reset during S_B aborts the request.
      a        = 64'h3FF0000000000000;
      b        = 64'h4000000000000000;
      db       = 1'b1;
      normal   = 1'b1;
      unary    = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst:busy_before", 64'(busy), 64'd1);
      checkOutput("midrst:f_a_before", 64'(f_a), 64'h10000000000000);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus("after_rst", 64'hC000000000000000, 64'h0000000000000003, 1'b1, 1'b0, 1'b0, 64'h0, 1);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         ra = randOperand();
         rb = randOperand();
         applyStimulus($sformatf("rnd%0d", n), ra, rb,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       {$urandom(), $urandom()}, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
